// File: rtl/kb_event_ctrl.sv
// PS/2 Set 2 scancode sequencer: folds E0/F0 prefixes into single key events,
// tracks shift/ctrl/caps state and queues events behind a valid/ready FIFO.
module kb_event_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_BITS  = 2
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte,
    input  logic       i_ready,
    input  logic       i_ovf_clr,
    output logic       o_valid,
    output logic [7:0] o_code,
    output logic       o_ext,
    output logic       o_break,
    output logic       o_shift,
    output logic       o_ctrl,
    output logic       o_caps,
    output logic       o_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(FIFO_DEPTH);

    state_t state_reg, state_next;
    logic   ev_valid, ev_ext, ev_brk;
    logic   is_prefix, is_silent;

    logic lshift_reg, rshift_reg, lctrl_reg, rctrl_reg, caps_reg, caps_down_reg;
    logic lshift_next, rshift_next, lctrl_next, rctrl_next, caps_next, caps_down_next;
    logic [12:0] entry_next;

    logic [12:0]          mem_reg [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_BITS:0]   count_reg;
    logic                 overflow_reg;
    logic                 full, pop, push_ok;
    logic [12:0]          head;

    assign is_prefix = (i_byte == 8'hE0) || (i_byte == 8'hF0);
    assign is_silent = (i_byte == 8'hAA) || (i_byte == 8'hFA) || (i_byte == 8'hEE) ||
                       (i_byte == 8'hFE) || (i_byte == 8'h00) || (i_byte == 8'hFF) ||
                       (i_byte == 8'hE1);

    always_comb begin
        state_next = state_reg;
        ev_valid   = 1'b0;
        ev_ext     = 1'b0;
        ev_brk     = 1'b0;
        if (i_byte_en) begin
            case (state_reg)
                S_IDLE: begin
                    if (i_byte == 8'hE0)      state_next = S_EXT;
                    else if (i_byte == 8'hF0) state_next = S_BRK;
                    else if (!is_silent)      ev_valid   = 1'b1;
                end
                S_EXT: begin
                    if (i_byte == 8'hF0)      state_next = S_EXT_BRK;
                    else if (i_byte != 8'hE0) begin
                        ev_valid   = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    // A prefix after F0 is a protocol error: drop it and resync.
                    state_next = S_IDLE;
                    ev_valid   = !is_prefix;
                    ev_brk     = 1'b1;
                end
                default: begin
                    state_next = S_IDLE;
                    ev_valid   = !is_prefix;
                    ev_ext     = 1'b1;
                    ev_brk     = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        lshift_next    = lshift_reg;
        rshift_next    = rshift_reg;
        lctrl_next     = lctrl_reg;
        rctrl_next     = rctrl_reg;
        caps_next      = caps_reg;
        caps_down_next = caps_down_reg;
        if (ev_valid) begin
            if (!ev_ext && i_byte == 8'h12) lshift_next = !ev_brk;
            if (!ev_ext && i_byte == 8'h59) rshift_next = !ev_brk;
            if (!ev_ext && i_byte == 8'h14) lctrl_next  = !ev_brk;
            if (ev_ext  && i_byte == 8'h14) rctrl_next  = !ev_brk;
            // Caps toggles only on the first make after a release, not on typematic repeats.
            if (!ev_ext && i_byte == 8'h58) begin
                if (ev_brk) begin
                    caps_down_next = 1'b0;
                end else begin
                    if (!caps_down_reg) caps_next = !caps_reg;
                    caps_down_next = 1'b1;
                end
            end
        end
    end

    assign entry_next = {i_byte, ev_ext, ev_brk, lshift_next | rshift_next,
                         lctrl_next | rctrl_next, caps_next};

    assign o_valid = (count_reg != '0);
    assign full    = (count_reg == DEPTH_CNT);
    assign pop     = o_valid && i_ready;
    assign push_ok = ev_valid && (!full || pop);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= S_IDLE;
            lshift_reg    <= 1'b0;
            rshift_reg    <= 1'b0;
            lctrl_reg     <= 1'b0;
            rctrl_reg     <= 1'b0;
            caps_reg      <= 1'b0;
            caps_down_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lshift_reg    <= lshift_next;
            rshift_reg    <= rshift_next;
            lctrl_reg     <= lctrl_next;
            rctrl_reg     <= rctrl_next;
            caps_reg      <= caps_next;
            caps_down_reg <= caps_down_next;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push_ok && pop) count_reg <= count_reg - 1'b1;
            // Set has priority over clear.
            if (ev_valid && full && !pop) overflow_reg <= 1'b1;
            else if (i_ovf_clr)           overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= entry_next;
    end

    // Data outputs read as zero whenever the queue is empty.
    assign head       = o_valid ? mem_reg[rd_ptr_reg] : '0;
    assign o_code     = head[12:5];
    assign o_ext      = head[4];
    assign o_break    = head[3];
    assign o_shift    = head[2];
    assign o_ctrl     = head[1];
    assign o_caps     = head[0];
    assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_kb_event_ctrl.sv
// Directed bench for kb_event_ctrl: scancode sequences with hand-computed events.
module tb_kb_event_ctrl;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_byte_en = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       i_ready = 1'b0;
    logic       i_ovf_clr = 1'b0;
    logic       o_valid, o_ext, o_break, o_shift, o_ctrl, o_caps, o_overflow;
    logic [7:0] o_code;
    logic [12:0] obs;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    kb_event_ctrl #(.FIFO_DEPTH(4), .ADDR_BITS(2)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_byte_en(i_byte_en), .i_byte(i_byte),
        .i_ready(i_ready), .i_ovf_clr(i_ovf_clr), .o_valid(o_valid), .o_code(o_code),
        .o_ext(o_ext), .o_break(o_break), .o_shift(o_shift), .o_ctrl(o_ctrl),
        .o_caps(o_caps), .o_overflow(o_overflow)
    );

    assign obs = {o_code, o_ext, o_break, o_shift, o_ctrl, o_caps};

    function automatic logic [12:0] ev(input logic [7:0] code, input logic ext, input logic brk,
                                       input logic sh, input logic ct, input logic cp);
        return {code, ext, brk, sh, ct, cp};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_byte    = b;
        i_byte_en = 1'b1;
        tick();
        i_byte_en = 1'b0;
    endtask

    task automatic pop_one();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic do_reset();
        i_byte_en = 1'b0;
        i_ready   = 1'b0;
        i_ovf_clr = 1'b0;
        #2 i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick();
        tests_run++;
        if (o_valid !== 1'b0 || o_overflow !== 1'b0 || obs !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset: got valid=%b ovf=%b ev=%h, required valid=0 ovf=0 ev=0000",
                     o_valid, o_overflow, obs);
        end
        i_rst_n = 1'b1;
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_make_break();
        do_reset();
        i_ready = 1'b1;
        send_byte(8'h1C);
        tests_run++;
        if (o_valid !== 1'b1 || obs !== ev(8'h1C, 0, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL mb_make: got valid=%b ev=%h, required valid=1 ev=%h",
                     o_valid, obs, ev(8'h1C, 0, 0, 0, 0, 0));
        end
        send_byte(8'hF0);
        tests_run++;
        if (o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mb_one_cycle: got valid=%b, required 0", o_valid);
        end
        send_byte(8'h1C);
        tests_run++;
        if (o_valid !== 1'b1 || obs !== ev(8'h1C, 0, 1, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL mb_break: got valid=%b ev=%h, required valid=1 ev=%h",
                     o_valid, obs, ev(8'h1C, 0, 1, 0, 0, 0));
        end
        tick();
        tests_run++;
        if (o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mb_drained: got valid=%b, required 0", o_valid);
        end
        i_ready = 1'b0;
        $display("[TB] test_make_break done");
    endtask

    task automatic test_modifiers();
        logic [12:0] exp_sh [4];
        logic [12:0] exp_ct [4];
        exp_sh = '{ev(8'h12, 0, 0, 1, 0, 0), ev(8'h1C, 0, 0, 1, 0, 0),
                   ev(8'h1C, 0, 1, 1, 0, 0), ev(8'h12, 0, 1, 0, 0, 0)};
        exp_ct = '{ev(8'h14, 1, 0, 0, 1, 0), ev(8'h59, 0, 0, 1, 1, 0),
                   ev(8'h14, 1, 1, 1, 0, 0), ev(8'h59, 0, 1, 0, 0, 0)};
        do_reset();
        send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0);
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (o_valid !== 1'b1 || obs !== exp_sh[k]) begin
                tests_failed++;
                $display("FAIL shift_ev%0d: got valid=%b ev=%h, required valid=1 ev=%h",
                         k, o_valid, obs, exp_sh[k]);
            end
            pop_one();
        end
        send_byte(8'hE0); send_byte(8'h14); send_byte(8'h59);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
        send_byte(8'hF0); send_byte(8'h59);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (o_valid !== 1'b1 || obs !== exp_ct[k]) begin
                tests_failed++;
                $display("FAIL ctrl_ev%0d: got valid=%b ev=%h, required valid=1 ev=%h",
                         k, o_valid, obs, exp_ct[k]);
            end
            pop_one();
        end
        $display("[TB] test_modifiers done");
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        tests_run++;
        if (o_valid !== 1'b1 || obs !== ev(8'h75, 1, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL ext_make: got valid=%b ev=%h, required valid=1 ev=%h",
                     o_valid, obs, ev(8'h75, 1, 0, 0, 0, 0));
        end
        pop_one();
        tests_run++;
        if (o_valid !== 1'b1 || obs !== ev(8'h75, 1, 1, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL ext_break: got valid=%b ev=%h, required valid=1 ev=%h",
                     o_valid, obs, ev(8'h75, 1, 1, 0, 0, 0));
        end
        pop_one();
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hE1);
        tests_run++;
        if (o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL silent_bytes: got valid=%b, required 0", o_valid);
        end
        $display("[TB] test_extended done");
    endtask

    task automatic test_caps();
        logic [2:0] exp_a;
        logic [1:0] exp_b;
        exp_a = 3'b111;
        exp_b = 2'b10;
        do_reset();
        send_byte(8'h58); send_byte(8'h58); send_byte(8'h58);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_valid !== 1'b1 || o_code !== 8'h58 || o_caps !== exp_a[2-k]) begin
                tests_failed++;
                $display("FAIL caps_rep%0d: got valid=%b code=%h caps=%b, required valid=1 code=58 caps=%b",
                         k, o_valid, o_code, o_caps, exp_a[2-k]);
            end
            pop_one();
        end
        send_byte(8'hF0); send_byte(8'h58); send_byte(8'h58);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (o_valid !== 1'b1 || o_code !== 8'h58 || o_caps !== exp_b[1-k]) begin
                tests_failed++;
                $display("FAIL caps_rel%0d: got valid=%b code=%h caps=%b, required valid=1 code=58 caps=%b",
                         k, o_valid, o_code, o_caps, exp_b[1-k]);
            end
            pop_one();
        end
        $display("[TB] test_caps done");
    endtask

    task automatic test_overflow();
        logic [7:0] codes [4];
        codes = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        tests_run++;
        if (o_valid !== 1'b1 || o_code !== 8'h11 || o_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set: got valid=%b code=%h ovf=%b, required valid=1 code=11 ovf=1",
                     o_valid, o_code, o_overflow);
        end
        i_ovf_clr = 1'b1;
        send_byte(8'h66);
        i_ovf_clr = 1'b0;
        tests_run++;
        if (o_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: got ovf=%b, required 1", o_overflow);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (o_valid !== 1'b1 || o_code !== codes[k]) begin
                tests_failed++;
                $display("FAIL ovf_drain%0d: got valid=%b code=%h, required valid=1 code=%h",
                         k, o_valid, o_code, codes[k]);
            end
            pop_one();
        end
        tests_run++;
        if (o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_empty: got valid=%b, required 0", o_valid);
        end
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        tests_run++;
        if (o_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clr: got ovf=%b, required 0", o_overflow);
        end
        $display("[TB] test_overflow done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [4];
        codes = '{8'h22, 8'h33, 8'h44, 8'h55};
        do_reset();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        i_ready = 1'b1;
        send_byte(8'h55);
        i_ready = 1'b0;
        tests_run++;
        if (o_overflow !== 1'b0 || o_valid !== 1'b1 || o_code !== 8'h22) begin
            tests_failed++;
            $display("FAIL full_push_pop: got ovf=%b valid=%b code=%h, required ovf=0 valid=1 code=22",
                     o_overflow, o_valid, o_code);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (o_valid !== 1'b1 || o_code !== codes[k]) begin
                tests_failed++;
                $display("FAIL b2b_drain%0d: got valid=%b code=%h, required valid=1 code=%h",
                         k, o_valid, o_code, codes[k]);
            end
            pop_one();
        end
        i_ready = 1'b1;
        send_byte(8'h66);
        i_ready = 1'b0;
        tests_run++;
        if (o_valid !== 1'b1 || obs !== ev(8'h66, 0, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL empty_push_pop: got valid=%b ev=%h, required valid=1 ev=%h",
                     o_valid, obs, ev(8'h66, 0, 0, 0, 0, 0));
        end
        tick();
        tests_run++;
        if (o_valid !== 1'b1 || o_code !== 8'h66) begin
            tests_failed++;
            $display("FAIL hold_stable: got valid=%b code=%h, required valid=1 code=66",
                     o_valid, o_code);
        end
        pop_one();
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_protocol_error();
        do_reset();
        send_byte(8'hF0); send_byte(8'hE0);
        tests_run++;
        if (o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL proto_no_event: got valid=%b, required 0", o_valid);
        end
        send_byte(8'h1C);
        tests_run++;
        if (o_valid !== 1'b1 || obs !== ev(8'h1C, 0, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL proto_resync: got valid=%b ev=%h, required valid=1 ev=%h",
                     o_valid, obs, ev(8'h1C, 0, 0, 0, 0, 0));
        end
        send_byte(8'hE0);
        #2 i_rst_n = 1'b0;
        #1;
        tests_run++;
        if (o_valid !== 1'b0 || obs !== 13'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b ev=%h, required valid=0 ev=0000", o_valid, obs);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
        send_byte(8'h1C);
        tests_run++;
        if (o_valid !== 1'b1 || obs !== ev(8'h1C, 0, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL prefix_discard: got valid=%b ev=%h, required valid=1 ev=%h",
                     o_valid, obs, ev(8'h1C, 0, 0, 0, 0, 0));
        end
        pop_one();
        $display("[TB] test_protocol_error done");
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_modifiers();
        test_extended();
        test_caps();
        test_overflow();
        test_back_to_back();
        test_protocol_error();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/kb_event_ctrl.md
Name: kb_event_ctrl

Overview:
Sequencing controller between the PS/2 byte receiver and downstream consumers (ASCII mapper, display logic). It consumes the raw scancode byte stream (Set 2) and resolves E0/F0 prefix sequences into single key events. It tracks the modifier state (shift, ctrl, caps-lock) and buffers events in a small FIFO. Events leave through a valid/ready handshake, so a slow consumer does not lose keystrokes.

Parameters:
FIFO_DEPTH, 4, number of event entries; power of two, minimum 2.
ADDR_BITS, 2, log2(FIFO_DEPTH).

Ports:
clk  input  1  system clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_byte_en  input  1  one-cycle strobe: i_byte holds a new received byte
i_byte  input  8  received scancode byte
i_ready  input  1  consumer accepts the head event this cycle
i_ovf_clr  input  1  synchronous clear of o_overflow
o_valid  output  1  FIFO head holds an event
o_code  output  8  event scancode (prefixes stripped)
o_ext  output  1  event was E0-prefixed
o_break  output  1  event is a release (F0-prefixed)
o_shift  output  1  shift snapshot for this event
o_ctrl  output  1  ctrl snapshot for this event
o_caps  output  1  caps-lock snapshot for this event
o_overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, i_rst_n=0): FSM = S_IDLE. All modifier flags = 0, caps = 0. FIFO empty. o_valid=0, o_overflow=0, and all data outputs = 0. Reset asserted mid-sequence discards partial prefixes and buffered events.
- The FSM advances only on cycles where i_byte_en=1. States: S_IDLE, S_EXT, S_BRK, S_EXT_BRK.
- S_IDLE transitions:
  - E0 -> S_EXT.
  - F0 -> S_BRK.
  - AA, FA, EE, FE, 00, FF, E1 -> consumed silently, stay in S_IDLE.
  - Any other byte -> make event (ext=0, brk=0), stay in S_IDLE.
- S_EXT transitions:
  - F0 -> S_EXT_BRK.
  - E0 -> stay in S_EXT.
  - Any other byte -> event (ext=1, brk=0) -> S_IDLE.
- S_BRK transitions:
  - E0 or F0 -> protocol error: no event -> S_IDLE.
  - Any other byte -> event (ext=0, brk=1) -> S_IDLE.
- S_EXT_BRK transitions:
  - E0 or F0 -> protocol error: no event -> S_IDLE.
  - Any other byte -> event (ext=1, brk=1) -> S_IDLE.
- Modifiers are updated in the same cycle the event is generated:
  - lshift = non-ext 12.
  - rshift = non-ext 59.
  - lctrl = non-ext 14.
  - rctrl = ext 14.
  - Each flag is set on make and cleared on break.
  - shift = lshift|rshift; ctrl = lctrl|rctrl.
- Caps-lock (non-ext 58):
  - A make toggles caps only if caps_down=0, then sets caps_down=1. Typematic repeats do not toggle.
  - A break clears caps_down.
- Event entry = {code, ext, brk, shift, ctrl, caps} = 13 bits. The snapshot is taken after the modifier update, so a shift make carries shift=1 and a shift break carries shift=0.
- Latency: event byte accepted at edge N -> o_valid=1 and data visible after edge N if the FIFO was empty (one-cycle latency).
- Handshake:
  - Pop on o_valid & i_ready.
  - Data and o_valid are held stable while o_valid & !i_ready.
  - i_ready with o_valid=0 has no effect.
- FIFO pointers are ADDR_BITS wide and wrap modulo FIFO_DEPTH. The count is ADDR_BITS+1 bits.
- Full, push with no pop: the event is dropped and o_overflow is set. FSM and modifiers still update.
- Full, push and pop in the same cycle: both take effect, count unchanged, no overflow.
- Empty, push and pop in the same cycle: the pop is ignored because o_valid=0; the push is stored.
- o_overflow is sticky until i_ovf_clr=1. If set and clear occur in the same cycle, set wins.

Test Plan:
- Reset, then bytes 1C, F0, 1C with i_ready=1 -> two events: {1C,ext0,brk0,shift0}, then {1C,ext0,brk1}. o_valid high exactly one cycle each.
- Bytes 12, 1C, F0, 1C, F0, 12 -> events 12 make (shift=1), 1C make (shift=1), 1C break (shift=1), 12 break (shift=0).
- Bytes E0, 75, E0, F0, 75 -> {75,ext1,brk0}, then {75,ext1,brk1}. Bytes AA and FA alone -> no events.
- Caps: 58, 58, 58 (repeat), F0, 58, 58 -> caps snapshots 1, 1, 1, 1, 0. Only the first make after a release toggles.
- i_ready=0, send 5 make codes (FIFO_DEPTH=4) -> o_valid=1, head = first code, o_overflow=1. Drain with i_ready=1 -> exactly 4 codes in order. i_ovf_clr -> o_overflow=0.
- F0 then E0 (protocol error), then 1C -> single make event {1C,ext0,brk0}. Assert i_rst_n=0 mid-prefix (after E0) -> o_valid=0 immediately, next 1C is a non-ext make.
